// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram overlay draw scheduler.
// Frame geometry defaults and the packed control word layout live here.
package hist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    CTRL,
    DRAW
  } state_t;

  localparam int CTRL_W = 36;
  localparam int WID_W  = 16;
  localparam int HGT_W  = 16;
  localparam int ILC_W  = 4;

  localparam int unsigned DEF_WIDTH  = 256;
  localparam int unsigned DEF_HEIGHT = 256;

  function automatic logic [CTRL_W-1:0] ctrl_word(
    input int unsigned w,
    input int unsigned h
  );
    return {WID_W'(w), HGT_W'(h), ILC_W'(0)};
  endfunction

endpackage

// File: rtl/hist_sched_cnt.sv
// Beat counter modulo MAX with a terminal-count flag.
// Wraps to zero only on an increment taken at the terminal value.
module hist_sched_cnt #(
  parameter int unsigned MAX = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic tc
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/hist_draw_sched.sv
// Frame scheduler between histogram accumulator, drawer and output mux.
// Optional frame skipping is enabled by defining HIST_DRAW_SKIP_EN.
module hist_draw_sched
  import hist_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int          DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              hist_done,
  output logic              hist_clear,
  output logic              id_valid,
  output logic [CTRL_W-1:0] ctrl_data,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic              draw_en,
  input  logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              busy,
`ifdef HIST_DRAW_SKIP_EN
  input  logic [3:0]        skip_n,
`endif
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CTRL_W-1:0] CTRL_WORD = ctrl_word(WIDTH, HEIGHT);

  state_t state;
  logic   pend;
  logic   pend_nxt;
  logic   take;
  logic   skip;
  logic   drop_inc;
  logic   beat;
  logic   tc;

  assign ctrl_data = CTRL_WORD;
  assign beat      = draw_en & pix_valid & pix_ready;

  hist_sched_cnt #(
    .MAX(WIDTH * HEIGHT)
  ) u_pix_cnt (
    .clk(clk),
    .rst(rst),
    .inc(beat),
    .tc (tc)
  );

`ifdef HIST_DRAW_SKIP_EN
  logic [3:0] skip_cnt;

  assign skip = take && (skip_cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt <= 4'd0;
    end else if (take) begin
      skip_cnt <= (skip_cnt == 4'd0) ? skip_n
                                     : skip_cnt - 4'd1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // A histogram arriving while one is already pending displaces it.
  always_comb begin
    take     = 1'b0;
    drop_inc = 1'b0;
    pend_nxt = pend;
    if (state == IDLE) begin
      take     = enable && (hist_done || pend);
      drop_inc = hist_done && !enable;
      if (skip) begin
        pend_nxt = 1'b0;
      end
    end else if (hist_done) begin
      pend_nxt = 1'b1;
      drop_inc = pend;
    end else if (state == LATCH) begin
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      drop_cnt   <= '0;
      hist_clear <= 1'b0;
      id_valid   <= 1'b0;
      ctrl_valid <= 1'b0;
      draw_en    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      hist_clear <= 1'b0;
      id_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (drop_inc && !(&drop_cnt)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (skip) begin
            hist_clear <= 1'b1;
          end else if (take) begin
            state      <= LATCH;
            id_valid   <= 1'b1;
            hist_clear <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LATCH: begin
          state      <= CTRL;
          ctrl_valid <= 1'b1;
        end
        CTRL: begin
          if (ctrl_ready) begin
            state      <= DRAW;
            ctrl_valid <= 1'b0;
            draw_en    <= 1'b1;
          end
        end
        DRAW: begin
          if (beat && tc) begin
            state      <= IDLE;
            draw_en    <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_draw_sched.sv
// Bench for hist_draw_sched: per-cycle model compare plus literal checks.
// Define HIST_DRAW_SKIP_EN to also exercise frame skipping.
module tb_hist_draw_sched;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
  localparam logic [35:0] PKT = 36'h000400020;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic hist_done = 1'b0;
  logic ctrl_ready = 1'b1;
  logic pix_valid = 1'b1;
  logic pix_ready = 1'b1;
  logic [3:0] skip_n = 4'd0;

  logic hist_clear, id_valid, ctrl_valid;
  logic draw_en, frame_done, busy;
  logic [35:0] ctrl_data;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hist_draw_sched #(
    .WIDTH(W),
    .HEIGHT(H),
    .DROP_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .hist_done(hist_done),
    .hist_clear(hist_clear),
    .id_valid(id_valid),
    .ctrl_data(ctrl_data),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .draw_en(draw_en),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .frame_done(frame_done),
    .busy(busy),
`ifdef HIST_DRAW_SKIP_EN
    .skip_n(skip_n),
`endif
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 latch, 2 ctrl, 3 draw; m_left beats to go.
  int m_mode = 0;
  int m_left = 0;
  int m_run = 0;
  logic m_pend = 1'b0;
  logic m_fd = 1'b0;
  logic m_sclr = 1'b0;
  logic [15:0] m_drop = 16'd0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_left <= 0; m_run <= 0;
      m_pend <= 1'b0; m_fd <= 1'b0; m_sclr <= 1'b0;
      m_drop <= 16'd0;
    end else begin
      m_fd <= 1'b0;
      m_sclr <= 1'b0;
      if (m_mode == 0) begin
        if (enable && (hist_done || m_pend)) begin
          if (m_run == 0) begin
            m_mode <= 1;
            m_run <= int'(skip_n);
          end else begin
            m_sclr <= 1'b1;
            m_pend <= 1'b0;
            m_run <= m_run - 1;
          end
        end else if (hist_done && !enable) begin
          m_drop <= sat(m_drop);
        end
      end else begin
        if (hist_done) begin
          m_pend <= 1'b1;
          if (m_pend) m_drop <= sat(m_drop);
        end else if (m_mode == 1) begin
          m_pend <= 1'b0;
        end
        if (m_mode == 1) m_mode <= 2;
        if (m_mode == 2 && ctrl_ready) begin
          m_mode <= 3;
          m_left <= N;
        end
        if (m_mode == 3 && pix_valid && pix_ready) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_mode <= 0;
            m_fd <= 1'b1;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("m_id_valid", id_valid, m_mode == 1);
    chk("m_hist_clear", hist_clear, (m_mode == 1) || m_sclr);
    chk("m_ctrl_valid", ctrl_valid, m_mode == 2);
    chk("m_draw_en", draw_en, m_mode == 3);
    chk("m_busy", busy, m_mode != 0);
    chk("m_frame_done", frame_done, m_fd);
    chk("m_drop_cnt", drop_cnt, m_drop);
    chk("m_ctrl_data", ctrl_data, PKT);
  end

  task automatic pulse();
    @(negedge clk) hist_done = 1'b1;
    @(negedge clk) hist_done = 1'b0;
  endtask

  task automatic wait_hi(input string nm, input int sel);
    logic s;
    for (int i = 0; i < 60; i++) begin
      unique case (sel)
        0: s = ctrl_valid;
        1: s = draw_en;
        default: s = frame_done;
      endcase
      if (s) return;
      @(negedge clk);
    end
    chk({"timeout_", nm}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int de, fd, fd_at, d0, idc, clc;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_draw_en", draw_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_ctrl_data", ctrl_data, PKT);
    rst = 1'b0;
    enable = 1'b1;

    // basic frame timing
    pulse();
    chk("t1_id_valid", id_valid, 1'b1);
    chk("t1_hist_clear", hist_clear, 1'b1);
    @(negedge clk);
    chk("t1_ctrl_valid", ctrl_valid, 1'b1);
    chk("t1_id_low", id_valid, 1'b0);
    de = 0; fd = 0;
    repeat (12) begin
      @(negedge clk);
      de += int'(draw_en);
      fd += int'(frame_done);
    end
    chk("t1_draw_cycles", de, 8);
    chk("t1_frame_done", fd, 1);

    // control packet back-pressure
    ctrl_ready = 1'b0;
    pulse();
    wait_hi("ctrl", 0);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", ctrl_valid, 1'b1);
      chk("t2_hold_data", ctrl_data, PKT);
      chk("t2_no_draw", draw_en, 1'b0);
    end
    ctrl_ready = 1'b1;
    wait_hi("fd2", 2);

    // pixel back-pressure
    pulse();
    wait_hi("draw3", 1);
    de = 0; fd = 0; fd_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      de += int'(draw_en);
      if (frame_done) begin
        fd++;
        fd_at = i;
      end
      pix_ready = i[0];
    end
    pix_ready = 1'b1;
    chk("t3_draw_cycles", de, 16);
    chk("t3_frame_done", fd, 1);
    chk("t3_fd_at", fd_at, 16);

    // pending and drops during a stalled frame
    d0 = int'(drop_cnt);
    pulse();
    wait_hi("draw4", 1);
    pix_valid = 1'b0;
    repeat (3) pulse();
    chk("t4_drops", int'(drop_cnt) - d0, 2);
    chk("t4_busy", busy, 1'b1);
    pix_valid = 1'b1;
    wait_hi("fd4", 2);
    @(negedge clk);
    chk("t4_restart", id_valid, 1'b1);
    wait_hi("fd4b", 2);

    // enable low: idle drop, then mid-frame disable
    enable = 1'b0;
    d0 = int'(drop_cnt);
    pulse();
    repeat (3) @(negedge clk);
    chk("t5_idle_drop", int'(drop_cnt) - d0, 1);
    chk("t5_idle_busy", busy, 1'b0);
    enable = 1'b1;
    pulse();
    wait_hi("draw5", 1);
    enable = 1'b0;
    pulse();
    wait_hi("fd5", 2);
    repeat (4) @(negedge clk);
    chk("t5_hold_idle", busy, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_resume", id_valid, 1'b1);
    wait_hi("fd5b", 2);

    // reset in the middle of a frame
    pulse();
    wait_hi("draw6", 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_draw", draw_en, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_drop", drop_cnt, 16'd0);
    @(negedge clk);
    chk("t6_no_fd", frame_done, 1'b0);
    rst = 1'b0;
    pulse();
    de = 0; fd = 0;
    repeat (14) begin
      @(negedge clk);
      de += int'(draw_en);
      fd += int'(frame_done);
    end
    chk("t6_draw_cycles", de, 8);
    chk("t6_frame_done", fd, 1);

`ifdef HIST_DRAW_SKIP_EN
    // skip two of every three histograms
    skip_n = 4'd2;
    idc = 0; clc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) hist_done = 1'b1;
      for (int j = 0; j < 19; j++) begin
        @(negedge clk);
        hist_done = 1'b0;
        idc += int'(id_valid);
        clc += int'(hist_clear);
      end
    end
    chk("t7_id_valid", idc, 2);
    chk("t7_hist_clear", clc, 6);
`else
    idc = 0; clc = 0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
